// File: rtl/vip_pkg.sv
// vip_pkg: shared video-pipeline word width and feature-map geometry defaults
package vip_pkg;
  localparam int VIP_DWIDTH = 32;
  localparam int VIP_IMG_W  = 112;
  localparam int VIP_IMG_H  = 112;
  localparam int VIP_POOL_W = VIP_IMG_W / 2;
  localparam int VIP_POOL_H = VIP_IMG_H / 2;
endpackage

// File: rtl/featuremap_relu_maxpool2x2_pool_line_buffer.sv
// pool_line_buffer: one row of horizontal pair maxima, sync write, async read
module pool_line_buffer #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 56,
  parameter int AW     = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DWIDTH-1:0] rdata
);
  logic [DWIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
  end
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/featuremap_relu_maxpool2x2.sv
// featuremap_relu_maxpool2x2: streaming ReLU followed by 2x2 max pooling
// between a conv-output FIFO and a downstream FIFO, one pixel per read.
module featuremap_relu_maxpool2x2
  import vip_pkg::*;
#(
  parameter int DWIDTH = VIP_DWIDTH,
  parameter int IMG_W  = VIP_IMG_W,
  parameter int IMG_H  = VIP_IMG_H
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DWIDTH-1:0] ff_rdata,
  input  logic              ff_empty,
  output logic              ff_rdreq,
  output logic [DWIDTH-1:0] ff_wdata,
  output logic              ff_wrreq,
  input  logic              ff_full,
  output logic              frame_done
);
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam int LB_D = IMG_W / 2;
  localparam int AW   = LB_D > 1 ? $clog2(LB_D) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  if ((IMG_W % 2) != 0 || IMG_W < 2 || (IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_size
    $error("featuremap_relu_maxpool2x2: IMG_W and IMG_H must be even and >= 2");
  end
  function automatic logic [DWIDTH-1:0] smax(input logic [DWIDTH-1:0] a, input logic [DWIDTH-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction
  logic              rd_vld_d, rd_vld_q;
  logic [CW-1:0]     col_d, col_q;
  logic [RW-1:0]     row_d, row_q;
  logic [DWIDTH-1:0] h_d, h_q;
  logic [DWIDTH-1:0] wdata_d, wdata_q;
  logic              wrreq_d, wrreq_q;
  logic              done_d, done_q;
  logic [DWIDTH-1:0] relu, h_max, pool, lb_rdata;
  logic [AW-1:0]     lb_addr;
  logic              lb_we;
  assign ff_rdreq = reset & ~ff_empty & ~ff_full;
  always_comb begin
    rd_vld_d = ff_rdreq;
    relu     = ff_rdata[DWIDTH-1] ? '0 : ff_rdata;
    h_max    = smax(h_q, relu);
    pool     = smax(h_max, lb_rdata);
    lb_addr  = AW'(col_q >> 1);
    col_d    = col_q;
    row_d    = row_q;
    h_d      = h_q;
    wdata_d  = wdata_q;
    wrreq_d  = 1'b0;
    done_d   = 1'b0;
    lb_we    = 1'b0;
    if (rd_vld_q) begin
      col_d   = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
      row_d   = (col_q != COL_LAST) ? row_q : (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      h_d     = col_q[0] ? h_q : relu;
      lb_we   = col_q[0] & ~row_q[0];
      wrreq_d = col_q[0] & row_q[0];
      wdata_d = wrreq_d ? pool : wdata_q;
      done_d  = wrreq_d && (col_q == COL_LAST) && (row_q == ROW_LAST);
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_vld_q <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      h_q      <= '0;
      wdata_q  <= '0;
      wrreq_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rd_vld_q <= rd_vld_d;
      col_q    <= col_d;
      row_q    <= row_d;
      h_q      <= h_d;
      wdata_q  <= wdata_d;
      wrreq_q  <= wrreq_d;
      done_q   <= done_d;
    end
  end
  // Even rows park the horizontal pair max; odd rows read it back at the same column pair.
  pool_line_buffer #(.DWIDTH(DWIDTH), .DEPTH(LB_D), .AW(AW)) u_line_buffer (
    .clock (clock),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (h_max),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );
  assign ff_wdata   = wdata_q;
  assign ff_wrreq   = wrreq_q;
  assign frame_done = done_q;
endmodule

// File: doc/featuremap_relu_maxpool2x2.md
FEATUREMAP_RELU_MAXPOOL2X2 -- requirements
Module: featuremap_relu_maxpool2x2

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, meaning the pixel word width (signed two's complement fixed point).
REQ-002 SHALL have parameter IMG_W, default 112, meaning input feature-map width in pixels.
REQ-003 SHALL have parameter IMG_H, default 112, meaning input feature-map height in pixels.
REQ-004 SHALL have port clock  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port ff_rdata  input  DWIDTH  upstream conv output FIFO read data, valid the cycle after ff_rdreq.
REQ-007 SHALL have port ff_empty  input  1  upstream FIFO (almost-)empty flag.
REQ-008 SHALL have port ff_rdreq  output  1  upstream FIFO read request.
REQ-009 SHALL have port ff_wdata  output  DWIDTH  pooled pixel to downstream FIFO.
REQ-010 SHALL have port ff_wrreq  output  1  downstream FIFO write strobe.
REQ-011 SHALL have port ff_full  input  1  downstream FIFO almost-full flag (margin >= 2 words).
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse coincident with the last pooled write of a frame.

Function
REQ-013 SHALL consume pixels raster order (row-major, col 0..IMG_W-1) and emit (IMG_W/2)*(IMG_H/2) outputs per frame, also raster order.
REQ-014 SHALL assert ff_rdreq = !ff_empty && !ff_full && reset deasserted; no other gating.
REQ-015 SHALL register a valid flag (rd_vld) one cycle after each ff_rdreq; only rd_vld cycles advance col/row counters.
REQ-016 SHALL apply ReLU to each valid sample: sign bit set -> 0, else unchanged.
REQ-017 SHALL, on even row: even col latch relu value in h_reg; odd col write max(h_reg, relu) to line buffer entry col>>1.
REQ-018 SHALL, on odd row: even col latch relu value in h_reg; odd col compute max(h_reg, relu, linebuf[col>>1]) and register it into ff_wdata.
REQ-019 SHALL compare signed (post-ReLU values are non-negative, so signed and unsigned agree; signed comparator mandatory regardless).
REQ-020 SHALL assert ff_wrreq for exactly one cycle, the cycle after the rd_vld of the odd-row/odd-col pixel (latency 1 from data valid, 2 from ff_rdreq).
REQ-021 SHALL tolerate up to 2 in-flight writes after ff_full rises; writes are never dropped or delayed by ff_full.
REQ-022 SHALL wrap col to 0 after IMG_W-1 and increment row; row wraps to 0 after IMG_H-1; next frame starts with no idle cycle.
REQ-023 SHALL pulse frame_done with the ff_wrreq for pixel (IMG_H-1, IMG_W-1).
REQ-024 SHALL hold ff_wdata stable between writes.
REQ-025 SHALL treat ff_empty and ff_full asserted simultaneously as no read; in-flight sample still processed.
REQ-026 SHALL require IMG_W and IMG_H even and >= 2; odd values SHALL fail elaboration.

Reset
REQ-027 SHALL, on reset low, asynchronously clear ff_rdreq, ff_wrreq, frame_done, rd_vld, col, row, h_reg and ff_wdata to 0.
REQ-028 SHALL NOT reset line buffer contents; every entry is rewritten on an even row before being read.
REQ-029 SHALL, on reset mid-frame, discard the partial frame; the first pixel after release is treated as (row 0, col 0).

Structure
REQ-030 SHALL take DWIDTH, IMG_W, IMG_H defaults from the shared package vip_pkg, alongside the existing feature-map size constants.
REQ-031 SHALL instantiate one sub-module pool_line_buffer: IMG_W/2 entries x DWIDTH, one synchronous write port, one combinational read port.
REQ-032 SHALL keep counters, ReLU, comparators and output registers in the top module; no FSM beyond col/row counters and rd_vld.

Verification (bench uses IMG_W=4, IMG_H=4)
REQ-033 Rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} -> outputs 6, 8, 14, 16, frame_done with 16.
REQ-034 All 16 inputs = 0xFFFFFFF0 (-16) -> four outputs = 0.
REQ-035 Window {-5,3,7,-1} at (0,0) -> first output 7; window of all-negative -> 0.
REQ-036 ff_full held high 10 cycles mid-frame -> ff_rdreq low those cycles, at most 2 writes during, output sequence identical to REQ-033.
REQ-037 Reset low after 6 pixels, release, then a full frame of REQ-033 data -> exactly outputs 6, 8, 14, 16, no stale values.
REQ-038 Two back-to-back frames with ff_empty never high -> 8 outputs, two frame_done pulses, 16 cycles apart.
